// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode encoding and sizing helper for the stream mux
package stream_mux_pkg;
  typedef enum logic [1:0] {MODE_SEL, MODE_FIXED, MODE_RR} mux_mode_e;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate / priority-encode / un-rotate arbiter
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);
  logic [N-1:0] rot;
  logic [W-1:0] p;
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = req[(i + int'(ptr)) % N];
    p = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) p = W'(i);
  end
  assign gnt_vld = |rot;
  assign gnt_idx = W'((int'(p) + int'(ptr)) % N);
endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: registered N-to-1 valid/ready stream mux with packet locking
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int WIDTH = 4,
  parameter int MODE = 2,
  localparam int SW = clog2_min1(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SW-1:0]           sel,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_last,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SW-1:0]           out_ch,
  input  logic                    out_ready
);
  localparam int NP = 2 ** SW;
  localparam mux_mode_e M = mux_mode_e'(MODE);
  logic lock, a_vld, gv, load, xfer;
  logic [SW-1:0] lock_ch, rr_ptr, arb_ptr, a_idx, g, nxt_ptr;
  logic [NP-1:0] v_pad, l_pad;
  logic [NP*WIDTH-1:0] d_pad;
  // zero-padding to a power of two makes an out-of-range sel read as "no valid"
  assign v_pad = NP'(in_valid);
  assign l_pad = NP'(in_last);
  assign d_pad = (NP*WIDTH)'(in_data);
  assign arb_ptr = (M == MODE_RR) ? rr_ptr : '0;
  rr_arbiter #(.N(N_CH)) u_arb (
    .req(in_valid),
    .ptr(arb_ptr),
    .gnt_idx(a_idx),
    .gnt_vld(a_vld)
  );
  assign g = lock ? lock_ch : (M == MODE_SEL) ? sel : a_idx;
  assign gv = lock ? v_pad[lock_ch] : (M == MODE_SEL) ? v_pad[sel] : a_vld;
  assign load = !out_valid || out_ready;
  assign xfer = !rst && load && gv;
  assign in_ready = xfer ? N_CH'(1) << g : '0;
  assign nxt_ptr = (int'(g) == N_CH - 1) ? '0 : g + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_ch <= '0;
      lock <= 1'b0;
      lock_ch <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= d_pad[g*WIDTH +: WIDTH];
      out_last <= l_pad[g];
      out_ch <= g;
      lock <= !l_pad[g];
      lock_ch <= g;
      if (M == MODE_RR && l_pad[g]) rr_ptr <= nxt_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
